// File: rtl/cpu_pkg.sv
// Shared front-end types: fetch-stage widths and the {pc, instr} entry that
// travels from fetch through decode and rename.
package cpu_pkg;

  localparam int ADDR_WIDTH  = 12;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode; absorbs decode stalls
// and supports a synchronous flush on redirect or mispredict.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [ADDR_WIDTH-1:0]        in_pc,
  input  logic [INSTR_WIDTH-1:0]       in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Local entry type follows the module parameters so non-default widths work.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              enq, deq;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_pc    = mem_q[head_q].pc;
  assign out_instr = mem_q[head_q].instr;
  assign count     = count_q;

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: the storage is cleared on reset so the head read is never X while empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) begin
        mem_q[tail_q] <= '{pc: in_pc, instr: in_instr};
      end
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue;

  localparam int AW    = 12;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_pc = '0;
  logic [IW-1:0] in_instr = '0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t model_q[$];

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of entries, updated from the inputs seen at the edge.
  always @(posedge clk) begin
    if (reset || flush) begin
      model_q.delete();
    end else begin
      bit do_enq, do_deq;
      do_enq = in_valid && (model_q.size() < DEPTH);
      do_deq = out_ready && (model_q.size() > 0);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back('{pc: in_pc, instr: in_instr});
    end
  end

  always @(negedge clk) begin
    check("m_count", 64'(count), 64'(model_q.size()));
    check("m_in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
    check("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("m_out_pc", 64'(out_pc), 64'(model_q[0].pc));
      check("m_out_instr", 64'(out_instr), 64'(model_q[0].instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
  endtask

  initial begin
    // Reset held two cycles while fetch keeps presenting data.
    reset = 1'b1; in_valid = 1'b1; in_pc = 12'h055; in_instr = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_reset_outputs("rst");
    end
    reset = 1'b0;

    // Fill with decode stalled.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_pc = AW'(4 * i); in_instr = 32'hA000_0000 + i;
      tick();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    in_pc = 12'h010; in_instr = 32'hA000_0010;
    tick();
    check("refuse_count", 64'(count), 64'd4);
    check("refuse_out_pc", 64'(out_pc), 64'h000);

    // Drain in order.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_pc", 64'(out_pc), 64'(4 * i));
      check("drain_instr", 64'(out_instr), 64'(32'hA000_0000 + i));
      tick();
    end
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // Streaming with simultaneous traffic across pointer wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = AW'(4 * i); in_instr = 32'hB000_0000 + i;
      tick();
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(out_pc), 64'(4 * i));
      check("stream_instr", 64'(out_instr), 64'(32'hB000_0000 + i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_count", 64'(count), 64'd0);

    // Flush with a simultaneous enqueue.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = AW'(12'h040 + 4 * i); in_instr = 32'hC000_0000 + i;
      tick();
    end
    check("preflush_count", 64'(count), 64'd3);
    flush = 1'b1; in_pc = 12'h100; in_instr = 32'hC000_0100;
    tick();
    flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    in_pc = 12'h200; in_instr = 32'hC000_0200;
    tick();
    check("postflush_valid", 64'(out_valid), 64'd1);
    check("postflush_pc", 64'(out_pc), 64'h200);
    check("postflush_instr", 64'(out_instr), 64'hC000_0200);

    // Reset mid-stream with both handshakes active.
    in_pc = 12'h204; in_instr = 32'hC000_0204;
    tick();
    check("premid_count", 64'(count), 64'd2);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 12'h300; in_instr = 32'hC000_0300;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    expect_reset_outputs("midrst");
    tick();
    expect_reset_outputs("midrst2");

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = AW'($urandom);
      in_instr  = $urandom;
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue
